sequential_unary_reduce: RTL and testbench

//   Multi-cycle, parametrised unary reduction unit (AND/OR/XOR, optionally inverted) over an N-bit operand.

---
 rtl/unary_reduce_pkg.sv | 24 ++
 rtl/unary_chunk_reduce.sv | 15 +
 rtl/sequential_unary_reduce.sv | 121 ++++++++++++
 tb/tb_sequential_unary_reduce.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/unary_reduce_pkg.sv
// Shared types and helpers for the sequential unary reduction unit:
// reduction kinds, the latched op record, FSM states and fold identity/absorbing values.
package unary_reduce_pkg;

  typedef enum logic [1:0] {RED_AND, RED_OR, RED_XOR, RED_RSVD} kind_t;

  typedef struct packed {
    logic  inv;
    kind_t kind;
  } op_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Starting accumulator value: AND starts at 1, OR and XOR start at 0.
  function automatic logic identity(kind_t k);
    return (k == RED_AND);
  endfunction

  // Value that pins the result for good: AND at 0, OR at 1 (XOR has none).
  function automatic logic absorbing(kind_t k);
    return (k == RED_OR);
  endfunction

endpackage

// File: rtl/unary_chunk_reduce.sv
// Combinational AND/OR/XOR reduction of one C-bit chunk of the operand.
module unary_chunk_reduce #(
  parameter int C = 8
) (
  input  logic [C-1:0] chunk_i,
  output logic         and_o,
  output logic         or_o,
  output logic         xor_o
);

  assign and_o = &chunk_i;
  assign or_o  = |chunk_i;
  assign xor_o = ^chunk_i;

endmodule

// File: rtl/sequential_unary_reduce.sv
// Multi-cycle unary reducer folding C bits per cycle, LSB chunk first, with valid/ready on both sides.
// Optional macro UNARY_REDUCE_EARLY_EXIT_EN: finish as soon as the accumulator hits the absorbing value.
module sequential_unary_reduce
  import unary_reduce_pkg::*;
#(
  parameter int N = 32,
  parameter int C = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [2:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_c,
  output logic         out_err,
  output logic         busy
);

  localparam int BEATS = N / C;
  localparam int BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d;
  logic           acc_q, acc_d;
  logic [BW-1:0]  beat_q, beat_d;
  op_t            op_q, op_d;
  logic           err_q, err_d;

  op_t            inOp;
  logic           chunkAnd, chunkOr, chunkXor;
  logic           accFold;
  logic           exitEarly;

  assign inOp = op_t'(in_op);

  unary_chunk_reduce #(.C(C)) u_chunk (
    .chunk_i (sh_q[C-1:0]),
    .and_o   (chunkAnd),
    .or_o    (chunkOr),
    .xor_o   (chunkXor)
  );

  always_comb begin
    case (op_q.kind)
      RED_AND: accFold = acc_q & chunkAnd;
      RED_OR:  accFold = acc_q | chunkOr;
      default: accFold = acc_q ^ chunkXor;
    endcase
  end

`ifdef UNARY_REDUCE_EARLY_EXIT_EN
  assign exitEarly = (op_q.kind != RED_XOR) && (accFold == absorbing(op_q.kind));
`else
  assign exitEarly = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    op_d    = op_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in_a;
          op_d    = inOp;
          beat_d  = '0;
          acc_d   = identity(inOp.kind);
          err_d   = (inOp.kind == RED_RSVD);
          // Reserved ops skip folding entirely and report an error.
          state_d = (inOp.kind == RED_RSVD) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d  = accFold;
        sh_d   = sh_q >> C;
        beat_d = beat_q + BW'(1);
        if ((beat_q == LAST_BEAT) || exitEarly) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      acc_q   <= 1'b0;
      beat_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      op_q    <= op_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_c     = out_valid & ~err_q & (acc_q ^ op_q.inv);
  assign out_err   = out_valid & err_q;

endmodule

// File: tb/tb_sequential_unary_reduce.sv
// Directed-vector and random bench for sequential_unary_reduce at N=32, C=8.
module tb_sequential_unary_reduce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [2:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic        out_c;
  logic        out_err;
  logic        busy;

  int vecCount  = 0;
  int missCount = 0;

  sequential_unary_reduce #(.N(32), .C(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [2:0]  op;
    logic        expC;
    logic        expErr;
    int          latFixed;
    int          latEarly;
  } vec_t;

  vec_t vecs[13];

  // Plain single-cycle reduction used as the reference for random operands.
  function automatic logic refReduce(input logic [31:0] a, input logic [2:0] op);
    logic r;
    case (op[1:0])
      2'b00:   r = &a;
      2'b01:   r = |a;
      2'b10:   r = ^a;
      default: return 1'b0;
    endcase
    return r ^ op[2];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Presents one op, waits for acceptance, then measures edges from accept until out_valid.
  task automatic applyStimulus(input logic [31:0] a, input logic [2:0] op, output int lat, output bit ok);
    int w;
    w = 0;
    ok = 1'b0;
    lat = -1;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_a     = a;
    in_op    = op;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("in_ready after accept", {31'b0, in_ready}, 32'd0);
    if (out_valid) begin
      lat = 0;
      ok  = 1'b1;
    end else begin
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = i;
          ok  = 1'b1;
          break;
        end
      end
    end
    if (!ok) checkOutput("result timeout", 32'd0, 32'd1);
  endtask

  task automatic consumeResult();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("out_valid after handshake", {31'b0, out_valid}, 32'd0);
    checkOutput("in_ready after handshake", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    int  lat;
    bit  ok;
    int  expLat;
    logic [31:0] ra;
    logic [2:0]  rop;
    logic        heldC;

    // Latencies are edges after the accepting edge; reserved ops are valid right away.
    vecs[0]  = '{"and_ones",     32'hFFFF_FFFF, 3'b000, 1'b1, 1'b0, 4, 4};
    vecs[1]  = '{"nand_ones",    32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0, 4, 4};
    vecs[2]  = '{"xor_7",        32'h0000_0007, 3'b010, 1'b1, 1'b0, 4, 4};
    vecs[3]  = '{"xor_ends",     32'h8000_0001, 3'b010, 1'b0, 1'b0, 4, 4};
    vecs[4]  = '{"and_lowzero",  32'hFFFF_FF00, 3'b000, 1'b0, 1'b0, 4, 1};
    vecs[5]  = '{"or_zero",      32'h0000_0000, 3'b001, 1'b0, 1'b0, 4, 4};
    vecs[6]  = '{"or_chunk2",    32'h0001_0000, 3'b001, 1'b1, 1'b0, 4, 3};
    vecs[7]  = '{"nor_chunk2",   32'h0001_0000, 3'b101, 1'b0, 1'b0, 4, 3};
    vecs[8]  = '{"rsvd",         32'h1234_5678, 3'b011, 1'b0, 1'b1, 0, 0};
    vecs[9]  = '{"rsvd_inv",     32'h1234_5678, 3'b111, 1'b0, 1'b1, 0, 0};
    vecs[10] = '{"xnor_3",       32'h0000_0003, 3'b110, 1'b1, 1'b0, 4, 4};
    vecs[11] = '{"and_chunk2",   32'hFF00_FFFF, 3'b000, 1'b0, 1'b0, 4, 3};
    vecs[12] = '{"or_chunk3",    32'h0100_0000, 3'b001, 1'b1, 1'b0, 4, 4};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'b0, busy}, 32'd0);
    checkOutput("reset in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset out_c", {31'b0, out_c}, 32'd0);
    checkOutput("reset out_err", {31'b0, out_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 13; i++) begin
`ifdef UNARY_REDUCE_EARLY_EXIT_EN
      expLat = vecs[i].latEarly;
`else
      expLat = vecs[i].latFixed;
`endif
      applyStimulus(vecs[i].a, vecs[i].op, lat, ok);
      if (ok) begin
        checkOutput({vecs[i].name, " out_c"}, {31'b0, out_c}, {31'b0, vecs[i].expC});
        checkOutput({vecs[i].name, " out_err"}, {31'b0, out_err}, {31'b0, vecs[i].expErr});
        checkOutput({vecs[i].name, " latency"}, lat, expLat);
        checkOutput({vecs[i].name, " busy"}, {31'b0, busy}, 32'd1);
        consumeResult();
      end
    end

    // Reset asserted while folding must abandon the operation.
    in_valid = 1'b1;
    in_a     = 32'hFFFF_FFFF;
    in_op    = 3'b000;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midrun reset busy", {31'b0, busy}, 32'd0);
    checkOutput("midrun reset in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(32'h0000_0007, 3'b010, lat, ok);
    if (ok) begin
      checkOutput("post reset xor out_c", {31'b0, out_c}, 32'd1);
      checkOutput("post reset xor latency", lat, 32'd4);
      consumeResult();
    end

    // Backpressure: result must hold and new requests must be ignored.
    applyStimulus(32'hFFFF_FFFF, 3'b100, lat, ok);
    if (ok) begin
      heldC = out_c;
      checkOutput("bp nand out_c", {31'b0, heldC}, 32'd0);
      for (int k = 0; k < 10; k++) begin
        in_valid = k[0];
        in_a     = 32'hFFFF_FFFF;
        in_op    = 3'b000;
        @(negedge clk);
        checkOutput("bp out_valid held", {31'b0, out_valid}, 32'd1);
        checkOutput("bp out_c held", {31'b0, out_c}, 32'd0);
        checkOutput("bp in_ready low", {31'b0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      consumeResult();
      @(negedge clk);
      checkOutput("bp no stray op busy", {31'b0, busy}, 32'd0);
      checkOutput("bp no second result", {31'b0, out_valid}, 32'd0);
    end

    // Reserved op followed by a normal AND clears the error flag.
    applyStimulus(32'hDEAD_BEEF, 3'b011, lat, ok);
    if (ok) begin
      checkOutput("rsvd2 out_err", {31'b0, out_err}, 32'd1);
      consumeResult();
    end
    applyStimulus(32'hFFFF_FFFF, 3'b000, lat, ok);
    if (ok) begin
      checkOutput("after rsvd out_err", {31'b0, out_err}, 32'd0);
      checkOutput("after rsvd out_c", {31'b0, out_c}, 32'd1);
      consumeResult();
    end

    // Random operands, ops and stalls against the single-cycle reference.
    for (int r = 0; r < 30; r++) begin
      ra  = $urandom;
      if (r % 3 == 0) ra = ra | 32'hFFFF_FF0F;
      rop = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      applyStimulus(ra, rop, lat, ok);
      if (ok) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        checkOutput("rand out_c", {31'b0, out_c}, {31'b0, refReduce(ra, rop)});
        checkOutput("rand out_err", {31'b0, out_err}, {31'b0, (rop[1:0] == 2'b11)});
        consumeResult();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
